// File: rtl/fisc_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fisc_mem_arbiter_pkg
// Shared definitions for the FISC memory arbiter slice:
//   - FISC width constants (integer word and memory word-address widths)
//   - default DATA_W / ADDR_W for the arbiter
//   - width of the read-latency counter
//   - arbiter FSM state encoding (IDLE is all-zero so a reset state reads 0)
// -----------------------------------------------------------------------------
package fisc_mem_arbiter_pkg;

   localparam int FISC_INTEGER_SZ = 64;
   localparam int FISC_ADDR_SZ    = 16;

   localparam int ARB_DATA_W_DEF  = FISC_INTEGER_SZ;
   localparam int ARB_ADDR_W_DEF  = FISC_ADDR_SZ;

   // Holds RD_LAT-1 for the legal RD_LAT range 1..7.
   localparam int ARB_LAT_W       = 3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/fisc_rr_arb2.sv
// -----------------------------------------------------------------------------
// fisc_rr_arb2
// Two-way round-robin picker, purely combinational.
//   req[1:0] : in  - request per port
//   last     : in  - index of the port granted most recently
//   gnt[1:0] : out - one-hot grant (all-zero when nothing requests)
// A lone requester always wins; on a tie the port that was not granted last
// wins.
// -----------------------------------------------------------------------------
module fisc_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/fisc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fisc_mem_arbiter
// Arbitrates two requesters (port 0 = instruction fetch, port 1 = load/store)
// onto a single-ported memory with a fixed read latency of RD_LAT cycles.
//
// Ports:
//   clk, reset_n          : clock (rising edge), synchronous active-low reset
//   hold_n                : 0 blocks new grants; an in-flight access finishes
//   req0/1, we0/1         : request, write(1)/read(0) per port
//   addr0/1, wdata0/1     : word address and write data per port
//   ack0/1                : one-cycle completion pulse per port
//   rdata0/1              : last read data captured for the port
//   mem_rd, mem_wr        : single-cycle memory strobes (only in ISSUE)
//   mem_addr, mem_wdata   : memory address / write data (driven in ISSUE)
//   mem_rdata             : memory read data, valid RD_LAT cycles after mem_rd
//   busy                  : high whenever the FSM is not in IDLE
//   dbg_state             : current FSM state
//
// Requester handshake: a requester raises reqN with weN/addrN/wdataN and keeps
// all of them stable until ackN pulses; it drops reqN on the edge that ends
// the ack cycle. req is only sampled in IDLE, so a request raised mid-access
// simply waits and is picked up on the next return to IDLE.
//
// Timing from the IDLE cycle in which a request is granted (cycle 0):
//   write: ISSUE(1) DONE(2)
//   read : ISSUE(1) WAIT(2 .. 1+RD_LAT) DONE(2+RD_LAT)
// -----------------------------------------------------------------------------
module fisc_mem_arbiter
   import fisc_mem_arbiter_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W_DEF,
   parameter int ADDR_W = ARB_ADDR_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hold_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output arb_state_t        dbg_state
);

   // WAIT counts down from RD_LAT-1 to 0; the zero cycle is the one in which
   // mem_rdata is valid.
   localparam logic [ARB_LAT_W-1:0] LAT_LOAD = ARB_LAT_W'(RD_LAT - 1);

   arb_state_t           state_q, state_d;
   logic                 grant_take;
   logic [1:0]           gnt;
   logic                 last_q;     // port granted most recently
   logic                 port_q;     // port owning the current access
   logic                 we_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [ARB_LAT_W-1:0] lat_cnt_q;
   logic [DATA_W-1:0]    rdata0_q, rdata1_q;

   fisc_rr_arb2 u_rr (
      .req  ({req1, req0}),
      .last (last_q),
      .gnt  (gnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and outputs
   always_comb begin
      state_d    = state_q;
      grant_take = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      busy       = 1'b1;

      case (state_q)
         ARB_IDLE: begin
            busy = 1'b0;
            if (hold_n && (req0 || req1)) begin
               grant_take = 1'b1;
               state_d    = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wr    = we_q;
            mem_rd    = !we_q;
            state_d   = we_q ? ARB_DONE : ARB_WAIT;
         end
         ARB_WAIT: begin
            if (lat_cnt_q == '0) begin
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            ack0    = !port_q;
            ack1    = port_q;
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Grant latch, latency counter and per-port read data
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q    <= 1'b1;        // favours port 0 on the first tie
         port_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lat_cnt_q <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         if (grant_take) begin
            case (gnt)
               2'b01: begin
                  port_q  <= 1'b0;
                  last_q  <= 1'b0;
                  we_q    <= we0;
                  addr_q  <= addr0;
                  wdata_q <= wdata0;
               end
               2'b10: begin
                  port_q  <= 1'b1;
                  last_q  <= 1'b1;
                  we_q    <= we1;
                  addr_q  <= addr1;
                  wdata_q <= wdata1;
               end
               default: begin
               end
            endcase
         end

         if (state_q == ARB_ISSUE) begin
            lat_cnt_q <= LAT_LOAD;
         end else if ((state_q == ARB_WAIT) && (lat_cnt_q != '0)) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
         end

         if ((state_q == ARB_WAIT) && (lat_cnt_q == '0)) begin
            if (port_q) begin
               rdata1_q <= mem_rdata;
            end else begin
               rdata0_q <= mem_rdata;
            end
         end
      end
   end

   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign dbg_state = state_q;

endmodule

// File: doc/fisc_mem_arbiter.md
FISC_MEM_ARBITER -- requirements
Module: fisc_mem_arbiter

Interface
REQ-001 The block SHALL use clock clk and reset reset_n, where reset is synchronous and active-low.
REQ-002 Parameter DATA_W, default 64: word width; equals FISC_INTEGER_SZ.
REQ-003 Parameter ADDR_W, default 16: memory word-address width.
REQ-004 Parameter RD_LAT, default 1, legal 1..7: cycles from mem_rd cycle to mem_rdata valid.
REQ-005 Port clk, in, 1: clock, all logic on rising edge.
REQ-006 Port reset_n, in, 1: synchronous active-low reset.
REQ-007 Port hold_n, in, 1: 0 = no new grant; the in-flight transaction completes.
REQ-008 Ports req0/req1, in, 1 each: request; port 0 = instruction fetch, port 1 = load/store.
REQ-009 Ports we0/we1, in, 1 each: 1 = write, 0 = read.
REQ-010 Ports addr0/addr1, in, ADDR_W each: word address.
REQ-011 Ports wdata0/wdata1, in, DATA_W each: write data.
REQ-012 Ports ack0/ack1, out, 1 each: one-cycle completion pulse.
REQ-013 Ports rdata0/rdata1, out, DATA_W each: read data, valid while the matching ack is high.
REQ-014 Ports mem_rd/mem_wr, out, 1 each: single-cycle memory strobes.
REQ-015 Ports mem_addr, out, ADDR_W, and mem_wdata, out, DATA_W: memory address and write data.
REQ-016 Port mem_rdata, in, DATA_W: memory read data.
REQ-017 Port busy, out, 1: high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states:
- IDLE: arbitrate.
- ISSUE: drive the memory strobe.
- WAIT: read latency.
- DONE: pulse ack.
REQ-019 In IDLE with hold_n=1 and any req high, the block SHALL grant one port and latch that port's we, addr and wdata, then go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: when req0 and req1 are both high, grant the port not granted last; a single requester is granted immediately.
REQ-021 ISSUE SHALL:
- last exactly one cycle;
- drive mem_addr and mem_wdata from the latch;
- pulse mem_wr=1 for a write (then go to DONE) or mem_rd=1 for a read (then go to WAIT).
REQ-022 WAIT SHALL:
- count RD_LAT cycles;
- capture mem_rdata into the granted port's rdata register in the last count cycle;
- then go to DONE.
REQ-023 DONE SHALL pulse the granted port's ack for exactly one cycle, then return to IDLE.
REQ-024 Latency from the first req-high cycle in IDLE to ack SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-025 Requester handshake:
- A requester SHALL hold req, we, addr and wdata stable until ack.
- A requester SHALL drop req on the edge ending the ack cycle.
- The block SHALL sample req only in IDLE.
REQ-026 hold_n=0 SHALL block only IDLE to ISSUE transitions; ISSUE, WAIT and DONE proceed unchanged.
REQ-027 Outside ISSUE, mem_rd and mem_wr SHALL be 0; ack0 and ack1 SHALL never be high together.
REQ-028 rdataN SHALL keep its last captured value until the next read on port N; writes leave it unchanged.
REQ-029 A req that rises during a transaction SHALL be served after DONE; no request is lost.

Reset
REQ-030 While reset_n=0, all outputs SHALL be 0, state SHALL be IDLE, and the round-robin pointer SHALL favour port 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction: no ack is issued and strobes drop on the reset edge.

Structure
REQ-032 The FSM state typedef and the DATA_W/ADDR_W defaults SHALL live in the shared package alongside the FISC width constants.
REQ-033 The round-robin picker SHALL be the single combinational sub-module fisc_rr_arb2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-034 Port 0 read addr 0x0010, RD_LAT=1, mem_rdata=0xDEADBEEF_00C0FFEE -> mem_rd in cycle 1; ack0 and rdata0=0xDEADBEEF_00C0FFEE in cycle 3.
REQ-035 Port 1 write addr 0x0020 data 0x1234 -> mem_wr with mem_addr=0x0020 in cycle 1; ack1 in cycle 2; rdata1 unchanged.
REQ-036 req0 and req1 both held for 4 transactions -> grant order 0,1,0,1, with exactly one ack per transaction.
REQ-037 hold_n=0 during ISSUE of a read -> that ack still arrives; a pending req1 is not granted until hold_n=1.
REQ-038 reset_n=0 during WAIT -> no ack, busy=0 on the next cycle, and a new req0 is granted normally afterwards.
REQ-039 RD_LAT=3, port 0 read -> ack0 exactly 5 cycles after req0 is first seen in IDLE.
